iiitb_pwm_btn_ctrl: RTL and testbench

- Upstream front end for iiitb_pwm_gen. Turns two raw, bouncy, asynchronous push-button inputs into clean single-cycle increase_duty / decrease_duty pulses.
- Per button: synchroniser, debounce counter and press/release FSM. Simultaneous presses are arbitrated, and an optional hold-to-repeat generator is provided.
- Outputs connect directly to the PWM generator's increase_duty / decrease_duty inputs.

---
 rtl/iiitb_pwm_btn_ctrl.sv | 174 +++++++++++++++++
 tb/tb_iiitb_pwm_btn_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iiitb_pwm_btn_ctrl.sv
// Push-button front end for iiitb_pwm_gen: synchronise, debounce and arbitrate two buttons into duty pulses.
// Optional hold-to-repeat generator is built when AUTO_REPEAT_EN is defined.
module iiitb_pwm_btn_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic increase_duty,
  output logic decrease_duty,
  output logic conflict,
  output logic inc_held,
  output logic dec_held
);

  localparam int unsigned NCH     = 2;
  localparam int unsigned CNT_M1  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_SAT = (CNT_M1 > REPEAT_PERIOD) ? CNT_M1 : REPEAT_PERIOD;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  logic [NCH-1:0] w_btn;
  logic [NCH-1:0] w_ev;
  logic [NCH-1:0] w_held_nxt;

  logic           r_inc;
  logic           r_dec;
  logic           r_conf;
  logic [NCH-1:0] r_held;

  assign w_btn = {btn_dec, btn_inc};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_s;
    logic                   w_db_ev;
    logic                   w_rep_ev;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[g]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Press/release debounce: a level must persist DEBOUNCE_CYCLES samples past the first to be accepted.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_db_ev     = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            w_state_nxt = ST_DB_PRESS;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_DB_PRESS: begin
          if (!w_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
            w_db_ev     = 1'b1;
          end else if (r_cnt < CNT_W'(CNT_SAT)) begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!w_s) begin
            w_state_nxt = ST_DB_RELEASE;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_DB_RELEASE: begin
          if (w_s) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt < CNT_W'(CNT_SAT)) begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_rcnt;
    logic             r_rarmed;
    logic             w_stay;

    // Repeat timer runs only while HELD persists; first target is REPEAT_DELAY, then REPEAT_PERIOD.
    assign w_stay   = (r_state == ST_HELD) && w_s;
    assign w_rep_ev = w_stay &&
                      (r_rcnt == (r_rarmed ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rcnt   <= '0;
        r_rarmed <= 1'b0;
      end else if (!w_stay) begin
        r_rcnt   <= '0;
        r_rarmed <= 1'b0;
      end else if (w_rep_ev) begin
        r_rcnt   <= '0;
        r_rarmed <= 1'b1;
      end else if (r_rcnt < CNT_W'(CNT_SAT)) begin
        r_rcnt   <= r_rcnt + CNT_W'(1);
      end
    end
`else
    assign w_rep_ev = 1'b0;
`endif

    assign w_ev[g]       = w_db_ev | w_rep_ev;
    assign w_held_nxt[g] = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DB_RELEASE);
  end

  // Coincident events cancel each other and are flagged instead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      r_conf <= 1'b0;
      r_held <= '0;
    end else begin
      r_inc  <= w_ev[0] & ~w_ev[1];
      r_dec  <= w_ev[1] & ~w_ev[0];
      r_conf <= w_ev[0] & w_ev[1];
      r_held <= w_held_nxt;
    end
  end

  assign increase_duty = r_inc;
  assign decrease_duty = r_dec;
  assign conflict      = r_conf;
  assign inc_held      = r_held[0];
  assign dec_held      = r_held[1];

endmodule

// File: tb/tb_iiitb_pwm_btn_ctrl.sv
// Directed bench for iiitb_pwm_btn_ctrl: per-cycle button waveforms with hand-computed pulse counts and timing.
module tb_iiitb_pwm_btn_ctrl;

  logic clk;
  logic reset;
  logic btn_inc;
  logic btn_dec;
  logic increase_duty;
  logic decrease_duty;
  logic conflict;
  logic inc_held;
  logic dec_held;

  int errors;
  int checks;

  iiitb_pwm_btn_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .increase_duty (increase_duty),
    .decrease_duty (decrease_duty),
    .conflict      (conflict),
    .inc_held      (inc_held),
    .dec_held      (dec_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit k of a mask is the button level set up before edge k; outputs are sampled 1 ns after edge k.
  typedef struct {
    string       name;
    logic [63:0] inc_m;
    logic [63:0] dec_m;
    int          n_inc;
    int          n_dec;
    int          n_conf;
    int          f_inc;
    int          f_dec;
    int          f_conf;
    int          n_ih;
    int          n_dh;
  } vec_t;

  localparam int NV   = 9;
  localparam int NCYC = 64;

  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
  endtask

  function automatic int outs();
    return int'({increase_duty, decrease_duty, conflict, inc_held, dec_held});
  endfunction

  task automatic run_vec(input vec_t v);
    int ni, nd, nc, fi, fd, fc, nih, ndh, ov;
    ni = 0; nd = 0; nc = 0; fi = -1; fd = -1; fc = -1; nih = 0; ndh = 0; ov = 0;
    do_reset();
    for (int k = 0; k < NCYC; k++) begin
      btn_inc = v.inc_m[k];
      btn_dec = v.dec_m[k];
      tick();
      if (increase_duty) begin ni++; if (fi < 0) fi = k; end
      if (decrease_duty) begin nd++; if (fd < 0) fd = k; end
      if (conflict)      begin nc++; if (fc < 0) fc = k; end
      if (inc_held) nih++;
      if (dec_held) ndh++;
      if (increase_duty && decrease_duty) ov++;
    end
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    chk({v.name, " inc_count"},   ni,  v.n_inc);
    chk({v.name, " dec_count"},   nd,  v.n_dec);
    chk({v.name, " conf_count"},  nc,  v.n_conf);
    chk({v.name, " inc_first"},   fi,  v.f_inc);
    chk({v.name, " dec_first"},   fd,  v.f_dec);
    chk({v.name, " conf_first"},  fc,  v.f_conf);
    chk({v.name, " inc_held_cyc"}, nih, v.n_ih);
    chk({v.name, " dec_held_cyc"}, ndh, v.n_dh);
    chk({v.name, " inc_dec_overlap"}, ov, 0);
  endtask

  initial begin
    int cnt;
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;

    vecs[0] = '{"clean_inc",     64'h3FF,         64'h0,      1, 0, 0,  6, -1, -1, 10,  0};
    vecs[1] = '{"bounce_dec",    64'h0,           64'h3FF5,   0, 1, 0, -1, 10, -1,  0, 10};
    vecs[2] = '{"glitch3",       64'h7,           64'h0,      0, 0, 0, -1, -1, -1,  0,  0};
    vecs[3] = '{"pulse5",        64'h1F,          64'h0,      1, 0, 0,  6, -1, -1,  5,  0};
    vecs[4] = '{"simultaneous",  64'h3FF,         64'h3FF,    0, 0, 1, -1, -1,  6, 10, 10};
    vecs[5] = '{"staggered",     64'h3FF,         64'h7FE,    1, 1, 0,  6,  7, -1, 10, 10};
    vecs[6] = '{"release_bnc",   64'h3FF3FF,      64'h0,      1, 0, 0,  6, -1, -1, 22,  0};
    vecs[7] = '{"overlap_hold",  64'hFFFFF,       64'h3FF00,  1, 1, 0,  6, 14, -1, 20, 10};
`ifdef AUTO_REPEAT_EN
    vecs[8] = '{"long_hold",     64'hFF_FFFF_FFFF, 64'h0,     4, 0, 0,  6, -1, -1, 40,  0};
`else
    vecs[8] = '{"long_hold",     64'hFF_FFFF_FFFF, 64'h0,     1, 0, 0,  6, -1, -1, 40,  0};
`endif

    // Reset held low with toggling buttons: outputs stay quiet.
    for (int k = 0; k < 3; k++) begin
      btn_inc = k[0];
      btn_dec = ~k[0];
      tick();
      chk("reset_hold_outs", outs(), 0);
    end
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    reset   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_reset_idle", outs(), 0);
    end

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset mid-debounce aborts the press.
    do_reset();
    btn_inc = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    reset   = 1'b0;
    btn_inc = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (outs() != 0) cnt++;
    end
    chk("abort_debounce_activity", cnt, 0);

    // Reset mid-hold clears the held level asynchronously.
    do_reset();
    btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("hold_before_abort", int'(inc_held), 1);
    #2;
    reset   = 1'b0;
    btn_inc = 1'b0;
    #1;
    chk("hold_async_clear", outs(), 0);
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (outs() != 0) cnt++;
    end
    chk("abort_hold_activity", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
